// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
//  Module   : updown_counter_param
//  Brief    : WIDTH-bit up/down counter, modulo MAX_VAL+1, with enable, load,
//             wrap/saturate mode, terminal-count flag and registered wrap pulse.
//             Optional sticky overflow flag: UPDOWN_COUNTER_OVF_STICKY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module updown_counter_param #(
    parameter int              WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             updown,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
    ,
    input  logic             ovf_clr,
    output logic             ovf_sticky
`endif
);

    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
    localparam bit               C_SAT = (SATURATE != 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             w_at_max, w_at_zero, w_hit;

    assign w_at_max  = (count_q == C_MAX);
    assign w_at_zero = (count_q == '0);
    assign w_hit     = en & ~load & (updown ? w_at_max : w_at_zero);

    // Reset masks tc so it never announces a wrap that reset will suppress.
    assign tc    = ~reset & w_hit;
    assign count = count_q;
    assign wrap  = wrap_q;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > C_MAX) ? C_MAX : load_val;
        end else if (en) begin
            if (updown) begin
                if (w_at_max) begin
                    wrap_d = 1'b1;
                    if (!C_SAT) count_d = '0;
                end else begin
                    count_d = count_q + C_ONE;
                end
            end else begin
                if (w_at_zero) begin
                    wrap_d = 1'b1;
                    if (!C_SAT) count_d = C_MAX;
                end else begin
                    count_d = count_q - C_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
    logic ovf_q, ovf_d;

    // A wrap registered on the same edge as a clear keeps the flag set.
    assign ovf_d      = wrap_d | (ovf_q & ~ovf_clr);
    assign ovf_sticky = ovf_q;

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_updown_counter_param.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
//  Module   : tb_updown_counter_param
//  Brief    : Scoreboard bench: directed vectors on wrap/saturate instances
//             (WIDTH=4, MAX_VAL=9) plus a free-running WIDTH=4 reference run.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_updown_counter_param;

    typedef struct {
        logic       rst, en, ud, ld, clr;
        logic [3:0] lv;
        logic       t0, t1;
        logic [3:0] c0, c1;
        logic       w0, w1;
        logic       cs, s0, s1;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, ud, ld;
    logic [3:0] lv;
    logic [3:0] c0, c1, cr;
    logic       t0, t1, tr, w0, w1, wr;
    logic       rst_r = 1'b1;
    logic       ud_r  = 1'b1;

    int   checks = 0;
    int   errors = 0;
    int   nvec   = 0;
    int   ref_cnt = 0;
    logic [3:0] ref_model = 4'd0;

    vec_t       q[$];
    logic [3:0] q_ref[$];

`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
    logic clr, s0, s1, sr;
`endif

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut0 (
        .clk(clk), .reset(rst), .en(en), .updown(ud), .load(ld), .load_val(lv),
        .count(c0), .tc(t0), .wrap(w0)
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        , .ovf_clr(clr), .ovf_sticky(s0)
`endif
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dut1 (
        .clk(clk), .reset(rst), .en(en), .updown(ud), .load(ld), .load_val(lv),
        .count(c1), .tc(t1), .wrap(w1)
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        , .ovf_clr(clr), .ovf_sticky(s1)
`endif
    );

    updown_counter_param #(.WIDTH(4)) dut_r (
        .clk(clk), .reset(rst_r), .en(1'b1), .updown(ud_r), .load(1'b0),
        .load_val(4'd0), .count(cr), .tc(tr), .wrap(wr)
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        , .ovf_clr(1'b0), .ovf_sticky(sr)
`endif
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic e, input logic u, input logic l,
                     input logic [3:0] val, input logic cl,
                     input logic et0, input logic et1,
                     input logic [3:0] ec0, input logic ew0,
                     input logic [3:0] ec1, input logic ew1,
                     input logic ecs, input logic es0, input logic es1);
        vec_t x;
        @(posedge clk);
        #2;
        rst = r; en = e; ud = u; ld = l; lv = val;
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        clr = cl;
`endif
        x.rst = r; x.en = e; x.ud = u; x.ld = l; x.lv = val; x.clr = cl;
        x.t0 = et0; x.t1 = et1; x.c0 = ec0; x.w0 = ew0; x.c1 = ec1; x.w1 = ew1;
        x.cs = ecs; x.s0 = es0; x.s1 = es1;
        q.push_back(x);
    endtask

    // tc is combinational: checked mid-cycle against the pending vector.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            chk("tc0", nvec, {31'd0, t0}, {31'd0, q[0].t0});
            chk("tc1", nvec, {31'd0, t1}, {31'd0, q[0].t1});
        end
    end

    always @(posedge clk) begin
        vec_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("count0", nvec, {28'd0, c0}, {28'd0, e.c0});
            chk("wrap0",  nvec, {31'd0, w0}, {31'd0, e.w0});
            chk("count1", nvec, {28'd0, c1}, {28'd0, e.c1});
            chk("wrap1",  nvec, {31'd0, w1}, {31'd0, e.w1});
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
            if (e.cs) begin
                chk("sticky0", nvec, {31'd0, s0}, {31'd0, e.s0});
                chk("sticky1", nvec, {31'd0, s1}, {31'd0, e.s1});
            end
`endif
            nvec++;
        end
    end

    // Reference run: updown toggles every 17 ns, offset off the clock grid.
    initial begin
        #100 rst_r = 1'b0;
    end
    initial begin
        #0.5;
        forever #17 ud_r = ~ud_r;
    end

    always @(posedge clk) begin
        if (ref_cnt < 60) begin
            if (rst_r) ref_model = 4'd0;
            else if (ud_r) ref_model = ref_model + 4'd1;
            else ref_model = ref_model - 4'd1;
            q_ref.push_back(ref_model);
            ref_cnt++;
        end
    end

    always @(posedge clk) begin
        logic [3:0] e;
        #1;
        if (q_ref.size() > 0) begin
            e = q_ref.pop_front();
            chk("ref_count", ref_cnt, {28'd0, cr}, {28'd0, e});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; en = 1'b0; ud = 1'b0; ld = 1'b0; lv = 4'd0;
`ifdef UPDOWN_COUNTER_OVF_STICKY_EN
        clr = 1'b0;
`endif
        // Reset with enable high: tc must stay low.
        v(1,1,1,0,4'd0,0, 0,0, 4'd0,0, 4'd0,0, 0,0,0);
        v(1,1,1,0,4'd0,0, 0,0, 4'd0,0, 4'd0,0, 0,0,0);
        v(1,1,1,0,4'd0,0, 0,0, 4'd0,0, 4'd0,0, 1,0,0);
        // Count up through MAX_VAL.
        for (int k = 0; k < 9; k++)
            v(0,1,1,0,4'd0,0, 0,0, 4'(k+1),0, 4'(k+1),0, 0,0,0);
        v(0,1,1,0,4'd0,0, 1,1, 4'd0,1, 4'd9,1, 0,0,0);
        v(0,1,1,0,4'd0,0, 0,1, 4'd1,0, 4'd9,1, 0,0,0);
        v(0,1,1,0,4'd0,0, 0,1, 4'd2,0, 4'd9,1, 0,0,0);
        // Load 0, count down through zero.
        v(0,1,0,1,4'd0,0, 0,0, 4'd0,0, 4'd0,0, 0,0,0);
        v(0,1,0,0,4'd0,0, 1,1, 4'd9,1, 4'd0,1, 0,0,0);
        v(0,1,0,0,4'd0,0, 0,1, 4'd8,0, 4'd0,1, 0,0,0);
        v(0,1,0,0,4'd0,0, 0,1, 4'd7,0, 4'd0,1, 0,0,0);
        // Load 9, strike the top three times, then reverse.
        v(0,1,1,1,4'd9,0, 0,0, 4'd9,0, 4'd9,0, 0,0,0);
        v(0,1,1,0,4'd0,0, 1,1, 4'd0,1, 4'd9,1, 0,0,0);
        v(0,1,1,0,4'd0,0, 0,1, 4'd1,0, 4'd9,1, 0,0,0);
        v(0,1,1,0,4'd0,0, 0,1, 4'd2,0, 4'd9,1, 0,0,0);
        v(0,1,0,0,4'd0,0, 0,0, 4'd1,0, 4'd8,0, 0,0,0);
        // Reversal at MAX_VAL decrements without a wrap.
        v(0,0,0,1,4'd9,0, 0,0, 4'd9,0, 4'd9,0, 0,0,0);
        v(0,1,0,0,4'd0,0, 0,0, 4'd8,0, 4'd8,0, 0,0,0);
        // Load clamps and clears wrap; reset beats load.
        v(0,0,0,1,4'd0,0, 0,0, 4'd0,0, 4'd0,0, 0,0,0);
        v(0,1,0,0,4'd0,0, 1,1, 4'd9,1, 4'd0,1, 0,0,0);
        v(0,1,1,1,4'd13,0, 0,0, 4'd9,0, 4'd9,0, 0,0,0);
        v(1,1,1,1,4'd4,0, 0,0, 4'd0,0, 4'd0,0, 0,0,0);
        // Hold with en low, wrap drops after a boundary event.
        v(0,0,1,0,4'd0,0, 0,0, 4'd0,0, 4'd0,0, 0,0,0);
        v(0,1,0,0,4'd0,0, 1,1, 4'd9,1, 4'd0,1, 0,0,0);
        v(0,0,0,0,4'd0,0, 0,0, 4'd9,0, 4'd0,0, 0,0,0);
        v(0,0,1,0,4'd0,0, 0,0, 4'd9,0, 4'd0,0, 0,0,0);
        // Reset mid-count masks tc.
        v(1,1,1,0,4'd0,0, 0,0, 4'd0,0, 4'd0,0, 0,0,0);
        v(0,0,0,1,4'd4,0, 0,0, 4'd4,0, 4'd4,0, 0,0,0);
        v(0,1,1,0,4'd0,0, 0,0, 4'd5,0, 4'd5,0, 0,0,0);
        // Sticky overflow set / clear / set-wins / reset.
        v(0,0,0,1,4'd0,0, 0,0, 4'd0,0, 4'd0,0, 1,0,0);
        v(0,1,0,0,4'd0,0, 1,1, 4'd9,1, 4'd0,1, 1,1,1);
        v(0,0,0,0,4'd0,0, 0,0, 4'd9,0, 4'd0,0, 1,1,1);
        v(0,0,0,0,4'd0,1, 0,0, 4'd9,0, 4'd0,0, 1,0,0);
        v(0,0,1,0,4'd0,0, 0,0, 4'd9,0, 4'd0,0, 1,0,0);
        v(0,1,1,0,4'd0,1, 1,0, 4'd0,1, 4'd1,0, 1,1,0);
        v(0,0,0,0,4'd0,0, 0,0, 4'd0,0, 4'd1,0, 1,1,0);
        v(1,0,0,0,4'd0,0, 0,0, 4'd0,0, 4'd0,0, 1,0,0);

        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (q.size() == 0 && q_ref.size() == 0 && ref_cnt >= 60) break;
        end
        #3;
        checks++;
        if (q.size() != 0 || q_ref.size() != 0 || ref_cnt < 60) begin
            errors++;
            $display("FAIL drain actual=%0d/%0d pending required=0/0", q.size(), q_ref.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
